// File: rtl/approx_err_monitor_if.sv
// rtl/approx_err_monitor_if.sv - sample/report handshake bundle for approx_err_monitor
// master = evaluation harness side, slave = monitor side.
interface approx_err_monitor_if #(
  parameter int WIDTH    = 16,
  parameter int WIN_LOG2 = 8
);
  logic                      in_valid;
  logic                      in_ready;
  logic [WIDTH-1:0]          a;
  logic [WIDTH-1:0]          b;
  logic [WIDTH:0]            approx_sum;
  logic                      flush;
  logic                      out_valid;
  logic                      out_ready;
  logic [WIN_LOG2:0]         n_samples;
  logic [WIN_LOG2:0]         err_cnt;
  logic [WIDTH+WIN_LOG2:0]   ed_sum;
  logic [WIDTH:0]            max_ed;
  logic [WIDTH:0]            mean_ed;

  modport master (
    output in_valid, a, b, approx_sum, flush, out_ready,
    input  in_ready, out_valid, n_samples, err_cnt, ed_sum, max_ed, mean_ed
  );

  modport slave (
    input  in_valid, a, b, approx_sum, flush, out_ready,
    output in_ready, out_valid, n_samples, err_cnt, ed_sum, max_ed, mean_ed
  );
endinterface

// File: rtl/approx_err_monitor.sv
// rtl/approx_err_monitor.sv - windowed error-distance statistics for approximate adders
// S1 computes |exact - approx| per sample, S2 accumulates; the FSM closes and reports windows.
module approx_err_monitor #(
  parameter int WIDTH    = 16,
  parameter int WIN_LOG2 = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  approx_err_monitor_if.slave  bus
);

  localparam int CW = WIN_LOG2 + 1;
  localparam int EW = WIDTH + 1;
  localparam int SW = WIDTH + 1 + WIN_LOG2;
  localparam logic [CW-1:0] WIN      = CW'(1) << WIN_LOG2;
  localparam logic [CW-1:0] WIN_LAST = WIN - CW'(1);

  typedef enum logic [1:0] {ACCUM, DRAIN, REPORT} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  acc_cnt_q;
  logic           s1_valid_q;
  logic [EW-1:0]  s1_ed_q;
  logic           s1_err_q;
  logic [CW-1:0]  proc_cnt_q;
  logic [CW-1:0]  err_acc_q;
  logic [SW-1:0]  ed_acc_q;
  logic [EW-1:0]  max_acc_q;
  logic           out_valid_q;
  logic [CW-1:0]  n_samples_q;
  logic [CW-1:0]  err_cnt_q;
  logic [SW-1:0]  ed_sum_q;
  logic [EW-1:0]  max_ed_q;
  logic [EW-1:0]  mean_ed_q;

  logic           in_ready_w;
  logic           accept_w;
  logic           latch_w;
  logic           release_w;
  logic [EW-1:0]  exact_w;
  logic [EW-1:0]  ed_w;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ACCUM;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (bus.flush || (accept_w && acc_cnt_q == WIN_LAST)) state_d = DRAIN;
      DRAIN:   if (latch_w) state_d = REPORT;
      REPORT:  if (release_w) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // flush wins over a concurrent sample; DRAIN waits for the S1 sample to land in S2
  always_comb begin
    in_ready_w = 1'b0;
    latch_w    = 1'b0;
    release_w  = 1'b0;
    case (state_q)
      ACCUM:   in_ready_w = (acc_cnt_q < WIN) && !bus.flush;
      DRAIN:   latch_w    = !s1_valid_q;
      REPORT:  release_w  = out_valid_q && bus.out_ready;
      default: ;
    endcase
    accept_w = bus.in_valid && in_ready_w;
  end

  assign exact_w = {1'b0, bus.a} + {1'b0, bus.b};
  assign ed_w    = (exact_w >= bus.approx_sum) ? (exact_w - bus.approx_sum)
                                               : (bus.approx_sum - exact_w);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_cnt_q   <= '0;
      s1_valid_q  <= 1'b0;
      s1_ed_q     <= '0;
      s1_err_q    <= 1'b0;
      proc_cnt_q  <= '0;
      err_acc_q   <= '0;
      ed_acc_q    <= '0;
      max_acc_q   <= '0;
      out_valid_q <= 1'b0;
      n_samples_q <= '0;
      err_cnt_q   <= '0;
      ed_sum_q    <= '0;
      max_ed_q    <= '0;
      mean_ed_q   <= '0;
    end else begin
      s1_valid_q <= accept_w;
      if (accept_w) begin
        s1_ed_q   <= ed_w;
        s1_err_q  <= (ed_w != '0);
        acc_cnt_q <= acc_cnt_q + CW'(1);
      end
      if (latch_w) begin
        n_samples_q <= proc_cnt_q;
        err_cnt_q   <= err_acc_q;
        ed_sum_q    <= ed_acc_q;
        max_ed_q    <= max_acc_q;
        mean_ed_q   <= ed_acc_q[SW-1 -: EW];
        out_valid_q <= 1'b1;
        proc_cnt_q  <= '0;
        err_acc_q   <= '0;
        ed_acc_q    <= '0;
        max_acc_q   <= '0;
        acc_cnt_q   <= '0;
      end else if (s1_valid_q) begin
        proc_cnt_q <= proc_cnt_q + CW'(1);
        err_acc_q  <= err_acc_q + CW'(s1_err_q);
        ed_acc_q   <= ed_acc_q + SW'(s1_ed_q);
        if (s1_ed_q > max_acc_q) max_acc_q <= s1_ed_q;
      end
      if (release_w) out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_q;
  assign bus.n_samples = n_samples_q;
  assign bus.err_cnt   = err_cnt_q;
  assign bus.ed_sum    = ed_sum_q;
  assign bus.max_ed    = max_ed_q;
  assign bus.mean_ed   = mean_ed_q;

endmodule

// File: tb/tb_approx_err_monitor.sv
// tb/tb_approx_err_monitor.sv - directed self-checking bench for approx_err_monitor
// Two instances: WIN_LOG2=2 for window/flush/reset behaviour, WIN_LOG2=8 for the worst-case sum.
module tb_approx_err_monitor;

  logic clk = 1'b0;
  logic rst_n;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  approx_err_monitor_if #(.WIDTH(16), .WIN_LOG2(2)) if2();
  approx_err_monitor_if #(.WIDTH(16), .WIN_LOG2(8)) if8();

  approx_err_monitor #(.WIDTH(16), .WIN_LOG2(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
  approx_err_monitor #(.WIDTH(16), .WIN_LOG2(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send2(input logic [15:0] a, input logic [15:0] b, input logic [16:0] s);
    int t = 0;
    @(negedge clk);
    if2.in_valid = 1'b1; if2.a = a; if2.b = b; if2.approx_sum = s;
    while (!if2.in_ready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) check("send2_timeout", 64'(if2.in_ready), 64'(1));
    @(posedge clk);
    #1 if2.in_valid = 1'b0;
  endtask

  task automatic send8(input logic [15:0] a, input logic [15:0] b, input logic [16:0] s);
    int t = 0;
    @(negedge clk);
    if8.in_valid = 1'b1; if8.a = a; if8.b = b; if8.approx_sum = s;
    while (!if8.in_ready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) check("send8_timeout", 64'(if8.in_ready), 64'(1));
    @(posedge clk);
    #1 if8.in_valid = 1'b0;
  endtask

  task automatic flush2(input logic with_sample);
    @(negedge clk);
    if2.flush = 1'b1;
    if2.in_valid = with_sample;
    if2.a = 16'h0000; if2.b = 16'h0000; if2.approx_sum = 17'h01000;
    #1 check("flush_in_ready", 64'(if2.in_ready), 64'(0));
    @(posedge clk);
    #1 if2.flush = 1'b0; if2.in_valid = 1'b0;
  endtask

  task automatic wait_rpt2(input string tag);
    int t = 0;
    while (!if2.out_valid && t < 100) begin @(negedge clk); t++; end
    check({tag, "_out_valid"}, 64'(if2.out_valid), 64'(1));
  endtask

  task automatic chk_rpt2(input string tag, input int n, input int e, input int s,
                          input int m, input int mean);
    check({tag, "_n_samples"}, 64'(if2.n_samples), 64'(n));
    check({tag, "_err_cnt"},   64'(if2.err_cnt),   64'(e));
    check({tag, "_ed_sum"},    64'(if2.ed_sum),    64'(s));
    check({tag, "_max_ed"},    64'(if2.max_ed),    64'(m));
    check({tag, "_mean_ed"},   64'(if2.mean_ed),   64'(mean));
  endtask

  task automatic release2(input string tag);
    @(negedge clk);
    if2.out_ready = 1'b1;
    @(posedge clk);
    #1 if2.out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_rel_out_valid"}, 64'(if2.out_valid), 64'(0));
    check({tag, "_rel_in_ready"},  64'(if2.in_ready),  64'(1));
  endtask

  initial begin
    int t;
    rst_n = 1'b0;
    if2.in_valid = 0; if2.a = 0; if2.b = 0; if2.approx_sum = 0; if2.flush = 0; if2.out_ready = 0;
    if8.in_valid = 0; if8.a = 0; if8.b = 0; if8.approx_sum = 0; if8.flush = 0; if8.out_ready = 0;
    apply_reset();
    check("rst_out_valid",  64'(if2.out_valid), 64'(0));
    check("rst_in_ready",   64'(if2.in_ready),  64'(1));
    check("rst_n_samples",  64'(if2.n_samples), 64'(0));
    check("rst_ed_sum",     64'(if2.ed_sum),    64'(0));
    check("rst8_out_valid", 64'(if8.out_valid), 64'(0));
    check("rst8_in_ready",  64'(if8.in_ready),  64'(1));

    // exact stream, latency of two edges after the last accept
    send2(16'h1234, 16'h0F0F, 17'h02143);
    send2(16'hFFFF, 16'h0001, 17'h10000);
    send2(16'h0000, 16'h0000, 17'h00000);
    send2(16'h8000, 16'h8000, 17'h10000);
    @(negedge clk);
    check("exact_lat_k0", 64'(if2.out_valid), 64'(0));
    check("exact_drain_in_ready", 64'(if2.in_ready), 64'(0));
    @(negedge clk);
    check("exact_lat_k1", 64'(if2.out_valid), 64'(0));
    @(negedge clk);
    check("exact_lat_k2", 64'(if2.out_valid), 64'(1));
    chk_rpt2("exact", 4, 0, 0, 0, 0);
    release2("exact");

    // ED in both directions plus backpressure
    send2(16'h000F, 16'h0001, 17'h00000);
    send2(16'hFFFF, 16'hFFFF, 17'h1FFFF);
    send2(16'h0001, 16'h0002, 17'h00003);
    send2(16'h0000, 16'h0000, 17'h00000);
    wait_rpt2("signed");
    chk_rpt2("signed", 4, 2, 17, 16, 4);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out_valid", 64'(if2.out_valid), 64'(1));
      check("bp_in_ready",  64'(if2.in_ready),  64'(0));
      check("bp_ed_sum",    64'(if2.ed_sum),    64'(17));
    end
    release2("bp");
    chk_rpt2("bp_hold", 4, 2, 17, 16, 4);

    // partial window closed by flush; flush-cycle sample rejected
    send2(16'h0010, 16'h0000, 17'h00015);
    send2(16'h0003, 16'h0004, 17'h00007);
    send2(16'h0100, 16'h0000, 17'h000F9);
    flush2(1'b1);
    wait_rpt2("flush");
    chk_rpt2("flush", 3, 2, 12, 7, 3);
    release2("flush");

    flush2(1'b0);
    wait_rpt2("empty");
    chk_rpt2("empty", 0, 0, 0, 0, 0);
    release2("empty");

    // reset mid-window discards the partial samples
    send2(16'h0000, 16'h0000, 17'h00100);
    send2(16'h0000, 16'h0000, 17'h00100);
    apply_reset();
    check("rstwin_out_valid", 64'(if2.out_valid), 64'(0));
    check("rstwin_in_ready",  64'(if2.in_ready),  64'(1));
    send2(16'h0000, 16'h0002, 17'h00003);
    send2(16'h0005, 16'h0005, 17'h0000C);
    send2(16'h0001, 16'h0001, 17'h00002);
    send2(16'h0000, 16'h0000, 17'h00000);
    wait_rpt2("postrst");
    chk_rpt2("postrst", 4, 2, 3, 2, 0);
    release2("postrst");

    // reset while a report is pending
    for (int i = 0; i < 4; i++) send2(16'h0000, 16'h0000, 17'h00040);
    wait_rpt2("midrpt");
    apply_reset();
    check("rstrpt_out_valid", 64'(if2.out_valid), 64'(0));
    check("rstrpt_in_ready",  64'(if2.in_ready),  64'(1));
    check("rstrpt_ed_sum",    64'(if2.ed_sum),    64'(0));
    check("rstrpt_n_samples", 64'(if2.n_samples), 64'(0));
    send2(16'h0000, 16'h0000, 17'h00009);
    flush2(1'b0);
    wait_rpt2("after_rpt_rst");
    chk_rpt2("after_rpt_rst", 1, 1, 9, 9, 2);
    release2("after_rpt_rst");

    // worst-case full window on the 256-sample instance
    for (int i = 0; i < 256; i++) send8(16'hFFFF, 16'hFFFF, 17'h00000);
    t = 0;
    while (!if8.out_valid && t < 100) begin @(negedge clk); t++; end
    check("worst_out_valid", 64'(if8.out_valid), 64'(1));
    check("worst_n_samples", 64'(if8.n_samples), 64'(256));
    check("worst_err_cnt",   64'(if8.err_cnt),   64'(256));
    check("worst_ed_sum",    64'(if8.ed_sum),    64'(32'h01FFFE00));
    check("worst_max_ed",    64'(if8.max_ed),    64'(32'h0001FFFE));
    check("worst_mean_ed",   64'(if8.mean_ed),   64'(32'h0001FFFE));
    @(negedge clk);
    if8.out_ready = 1'b1;
    @(posedge clk);
    #1 if8.out_ready = 1'b0;
    @(negedge clk);
    check("worst_rel_out_valid", 64'(if8.out_valid), 64'(0));
    check("worst_rel_in_ready",  64'(if8.in_ready),  64'(1));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
